fifo_rd_packer: RTL and testbench

Read-side consumer of the asynchronous FIFO, running entirely in the read clock domain. Drains bytes through the FIFO's ren/empty/rd_data interface and honours its one-cycle registered read latency. Packs PACK consecutive bytes little-endian into one wide word, presented on a valid/ready output. A flush request emits a partial word with byte enables.

---
 rtl/fifo_rd_packer.sv | 143 ++++++++++++++
 tb/tb_fifo_rd_packer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: drains bytes through ren/empty/rd_data and packs
// PACK lanes little-endian into one word on a valid/ready output, with flush.
//
// state   | meaning
// S_FILL  | issue reads and capture landing bytes into the assembly register
// S_HOLD  | present out_data/out_be with out_valid until out_ready
// S_FLUSH | emit the partial word (if any lanes filled) and clear flush_req
module fifo_rd_packer #(
   parameter int DATA_W = 8,
   parameter int PACK   = 4,
   parameter int LANE_W = 2
) (
   input  logic                     rclk,
   input  logic                     rst,
   input  logic                     empty,
   input  logic [DATA_W-1:0]        rd_data,
   output logic                     ren,
   input  logic                     flush,
   output logic [DATA_W*PACK-1:0]   out_data,
   output logic [PACK-1:0]          out_be,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy
);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_HOLD  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [LANE_W-1:0]        r_lane;
   logic                     r_pend;
   logic                     r_flush_req;
   logic [DATA_W*PACK-1:0]   r_asm;
   logic [DATA_W*PACK-1:0]   r_out_data;
   logic [PACK-1:0]          r_out_be;
   logic                     r_out_valid;

   logic [DATA_W*PACK-1:0]   w_asm_ins;
   logic [PACK-1:0]          w_flush_be;
   logic                     w_last;
   logic                     w_hs;
   logic                     w_ren;

   assign w_last = (r_lane == LANE_W'(PACK-1));
   assign w_hs   = r_out_valid & out_ready;

   // Assembly register with the landing byte dropped into the current lane
   always_comb begin
      w_asm_ins = r_asm;
      w_asm_ins[r_lane*DATA_W +: DATA_W] = rd_data;
   end

   always_comb begin
      w_flush_be = '0;
      for (int i = 0; i < PACK; i++) begin
         w_flush_be[i] = (LANE_W'(i) < r_lane);
      end
   end

   // State register
   always_ff @(posedge rclk) begin
      if (rst) r_state <= S_FILL;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; a landing byte that completes a word wins over flush
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FILL: begin
            if (r_pend && w_last)              w_state_nxt = S_HOLD;
            else if (r_flush_req && !r_pend)   w_state_nxt = S_FLUSH;
         end
         S_HOLD: begin
            if (w_hs) w_state_nxt = S_FILL;
         end
         S_FLUSH: begin
            w_state_nxt = (r_lane != '0) ? S_HOLD : S_FILL;
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   // Output logic: reads stop one lane early when the last byte is in flight
   always_comb begin
      w_ren = (r_state == S_FILL) & ~empty & ~r_flush_req & ~(r_pend & w_last);
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         r_lane      <= '0;
         r_pend      <= 1'b0;
         r_flush_req <= 1'b0;
         r_asm       <= '0;
         r_out_data  <= '0;
         r_out_be    <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_pend      <= w_ren;
         r_flush_req <= flush | (r_flush_req & (r_state != S_FLUSH));
         case (r_state)
            S_FILL: begin
               if (r_pend) begin
                  if (w_last) begin
                     r_out_data  <= w_asm_ins;
                     r_out_be    <= '1;
                     r_out_valid <= 1'b1;
                     r_lane      <= '0;
                     r_asm       <= '0;
                  end else begin
                     r_asm       <= w_asm_ins;
                     r_lane      <= r_lane + LANE_W'(1);
                  end
               end
            end
            S_HOLD: begin
               if (w_hs) r_out_valid <= 1'b0;
            end
            S_FLUSH: begin
               if (r_lane != '0) begin
                  r_out_data  <= r_asm;
                  r_out_be    <= w_flush_be;
                  r_out_valid <= 1'b1;
                  r_lane      <= '0;
                  r_asm       <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign ren       = w_ren;
   assign out_data  = r_out_data;
   assign out_be    = r_out_be;
   assign out_valid = r_out_valid;
   assign busy      = r_pend | (r_lane != '0) | r_out_valid | r_flush_req;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-based FIFO model and a byte-stream packing
// model that predicts the sequence of emitted words; directed plus random.
module tb_fifo_rd_packer;

   logic        rclk = 1'b0;
   logic        rst = 1'b1;
   logic        empty = 1'b1;
   logic [7:0]  rd_data = '0;
   logic        ren;
   logic        flush = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_be;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;

   fifo_rd_packer #(.DATA_W(8), .PACK(4), .LANE_W(2)) dut (
      .rclk(rclk), .rst(rst), .empty(empty), .rd_data(rd_data), .ren(ren),
      .flush(flush), .out_data(out_data), .out_be(out_be),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   always #5 rclk = ~rclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int          checks = 0;
   int          errors = 0;
   int          n_ren  = 0;
   logic [7:0]  fifo_q[$];
   logic [31:0] exp_d[$];
   logic [3:0]  exp_be[$];
   logic [31:0] got_d[$];
   logic [3:0]  got_be[$];
   logic [31:0] cur_word = '0;
   int          cur_n = 0;
   bit          inflight = 0;
   logic        prev_ov = 0;
   logic        prev_rdy = 0;
   logic [31:0] prev_od = '0;
   logic [3:0]  prev_be = '0;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
   endtask

   task automatic cyc(input bit fl, input bit rdy);
      logic [7:0] b;
      bit sr;
      @(negedge rclk);
      empty = (fifo_q.size() == 0);
      flush = fl;
      out_ready = rdy;
      #1;
      sr = ren;
      chk(!(sr && empty), "ren_while_empty", 32'(sr), 0);
      chk(!(sr && out_valid), "ren_while_valid", 32'(sr), 0);
      if (prev_ov && !prev_rdy) begin
         chk(out_valid === 1'b1, "hold_valid", 32'(out_valid), 1);
         chk(out_data === prev_od, "hold_data", out_data, prev_od);
         chk(out_be === prev_be, "hold_be", 32'(out_be), 32'(prev_be));
      end
      if (cur_n != 0 || out_valid || inflight)
         chk(busy === 1'b1, "busy_set", 32'(busy), 1);
      if (out_valid && rdy) begin
         got_d.push_back(out_data);
         got_be.push_back(out_be);
         if (exp_d.size() == 0) begin
            chk(0, "unexpected_word", out_data, 0);
         end else begin
            logic [31:0] ed;
            logic [3:0]  eb;
            ed = exp_d.pop_front();
            eb = exp_be.pop_front();
            chk(out_data === ed, "word_data", out_data, ed);
            chk(out_be === eb, "word_be", 32'(out_be), 32'(eb));
         end
      end
      prev_ov = out_valid; prev_rdy = rdy; prev_od = out_data; prev_be = out_be;
      b = 8'h00;
      if (sr) begin
         n_ren++;
         if (fifo_q.size() > 0) b = fifo_q.pop_front();
         cur_word = cur_word | (32'(b) << (8 * cur_n));
         cur_n++;
         if (cur_n == 4) begin
            exp_d.push_back(cur_word);
            exp_be.push_back(4'hF);
            cur_word = '0;
            cur_n = 0;
         end
      end
      if (fl && cur_n != 0) begin
         exp_d.push_back(cur_word);
         exp_be.push_back(4'((1 << cur_n) - 1));
         cur_word = '0;
         cur_n = 0;
      end
      inflight = sr;
      @(posedge rclk);
      #1;
      if (sr) rd_data = b;
   endtask

   task automatic do_reset();
      @(negedge rclk);
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0; empty = 1'b1;
      fifo_q.delete();
      repeat (2) @(negedge rclk);
      #1;
      chk(out_valid === 1'b0, "rst_out_valid", 32'(out_valid), 0);
      chk(out_data === 32'h0, "rst_out_data", out_data, 0);
      chk(out_be === 4'h0, "rst_out_be", 32'(out_be), 0);
      chk(busy === 1'b0, "rst_busy", 32'(busy), 0);
      chk(ren === 1'b0, "rst_ren", 32'(ren), 0);
      rst = 1'b0;
      exp_d.delete(); exp_be.delete();
      cur_word = '0; cur_n = 0; inflight = 0;
      prev_ov = 0; prev_rdy = 0;
   endtask

   task automatic run_until_word(input int max);
      int s;
      int k;
      s = got_d.size();
      k = 0;
      while (got_d.size() == s && k < max) begin
         cyc(0, 1);
         k++;
      end
      chk(got_d.size() > s, "word_timeout", 32'(got_d.size()), 32'(s + 1));
   endtask

   task automatic wait_idle(input int max);
      int k;
      k = 0;
      while ((busy !== 1'b0 || fifo_q.size() != 0) && k < max) begin
         cyc(0, 1);
         k++;
      end
      chk(busy === 1'b0, "idle_timeout", 32'(busy), 0);
   endtask

   initial begin
      int s;
      int n0;

      // 1: single word held until handshake
      do_reset();
      n_ren = 0;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      repeat (8) cyc(0, 0);
      chk(n_ren == 4, "t1_ren_count", 32'(n_ren), 4);
      chk(out_valid === 1'b1, "t1_valid", 32'(out_valid), 1);
      chk(out_data === 32'h44332211, "t1_data", out_data, 32'h44332211);
      chk(out_be === 4'hF, "t1_be", 32'(out_be), 32'hF);
      cyc(0, 1);
      chk(got_d[$] === 32'h44332211, "t1_hs_data", got_d[$], 32'h44332211);

      // 2: two back-to-back words
      s = got_d.size();
      for (int i = 1; i <= 8; i++) push(8'(i));
      repeat (14) cyc(0, 1);
      chk(got_d.size() == s + 2, "t2_count", 32'(got_d.size() - s), 2);
      chk(got_d[$-1] === 32'h04030201, "t2_word0", got_d[$-1], 32'h04030201);
      chk(got_d[$] === 32'h08070605, "t2_word1", got_d[$], 32'h08070605);

      // 3: flush of an idle partial word
      s = got_d.size();
      push(8'hAA); push(8'hBB);
      repeat (6) cyc(0, 1);
      chk(got_d.size() == s, "t3_no_early_word", 32'(got_d.size()), 32'(s));
      cyc(1, 1);
      run_until_word(20);
      chk(got_d[$] === 32'h0000BBAA, "t3_data", got_d[$], 32'h0000BBAA);
      chk(got_be[$] === 4'b0011, "t3_be", 32'(got_be[$]), 32'h3);
      repeat (3) cyc(0, 1);
      chk(busy === 1'b0, "t3_busy_after", 32'(busy), 0);

      // 4: flush coincident with the read of the third byte
      push(8'h01); push(8'h02); push(8'h03);
      cyc(0, 1);
      cyc(0, 1);
      n0 = n_ren;
      cyc(1, 1);
      chk(n_ren == n0 + 1, "t4_ren_with_flush", 32'(n_ren - n0), 1);
      run_until_word(20);
      chk(got_d[$] === 32'h00030201, "t4_data", got_d[$], 32'h00030201);
      chk(got_be[$] === 4'b0111, "t4_be", 32'(got_be[$]), 32'h7);
      wait_idle(20);

      // 5: backpressure with more data waiting
      s = got_d.size();
      for (int i = 1; i <= 8; i++) push(8'(8'h50 + i));
      repeat (16) cyc(0, 0);
      chk(fifo_q.size() == 4, "t5_no_extra_reads", 32'(fifo_q.size()), 4);
      chk(out_data === 32'h54535251, "t5_held_data", out_data, 32'h54535251);
      repeat (12) cyc(0, 1);
      chk(got_d.size() == s + 2, "t5_count", 32'(got_d.size() - s), 2);
      chk(got_d[$] === 32'h58575655, "t5_word1", got_d[$], 32'h58575655);

      // 6: reset mid-word, then a clean word
      push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
      repeat (3) cyc(0, 1);
      do_reset();
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
      run_until_word(20);
      chk(got_d[$] === 32'hC4C3C2C1, "t6_data", got_d[$], 32'hC4C3C2C1);
      chk(got_be[$] === 4'hF, "t6_be", 32'(got_be[$]), 32'hF);

      // Random traffic against the packing model
      do_reset();
      repeat (4000) begin
         if ($urandom_range(0, 99) < 55) push(8'($urandom()));
         cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60);
      end
      wait_idle(200);
      cyc(1, 1);
      wait_idle(50);
      chk(exp_d.size() == 0, "all_words_out", 32'(exp_d.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
